led_fader: RTL



---
 rtl/led_fader_pkg.sv | 16 +
 rtl/led_pwm.sv | 40 ++++
 rtl/led_fader.sv | 113 +++++++++++
 3 files changed

// File: rtl/led_fader_pkg.sv
// Shared types and sizing helpers for the LED fader and its PWM back end.
package led_fader_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } state_t;

  // Level spans 0..2**pwm_bits inclusive, so it needs one bit more than the counter.
  function automatic int level_width(input int pwm_bits);
    return pwm_bits + 1;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM generator; duty is latched only at period boundaries so the
// output never glitches mid-period. duty = 2**PWM_BITS gives a constant 1.
module led_pwm
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [level_width(PWM_BITS)-1:0]     duty,
  output logic                                 pwm_out
);

  localparam int LW = level_width(PWM_BITS);
  localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [LW-1:0]       duty_q_r;
  logic                pwm_out_r;

  // Period counter, boundary duty latch and registered compare.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt_r <= {PWM_BITS{1'b0}};
      duty_q_r  <= {LW{1'b0}};
      pwm_out_r <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      if (pwm_cnt_r == CNT_MAX) begin
        duty_q_r <= duty;
      end else begin
        duty_q_r <= duty_q_r;
      end
      pwm_out_r <= ({1'b0, pwm_cnt_r} < duty_q_r);
    end
  end

  assign pwm_out = pwm_out_r;

endmodule

// File: rtl/led_fader.sv
// Ramps LED brightness linearly toward led_in and drives it as PWM on led_out.
// Define LED_FADER_GAMMA_EN to map level through a square law before the PWM.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int STEP_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              led_in,
  output logic                              led_out,
  output logic [level_width(PWM_BITS)-1:0]  level,
  output logic                              settled
);

  localparam int LW = level_width(PWM_BITS);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [LW-1:0] FULL = {1'b1, {PWM_BITS{1'b0}}};
  localparam logic [LW-1:0] ZERO = {LW{1'b0}};
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  state_t        state_r;
  logic [LW-1:0] level_r;
  logic          settled_r;
  logic [SW-1:0] step_cnt_r;

  logic          step_tick_s;
  logic [LW-1:0] target_s;
  logic [LW-1:0] level_up_s;
  logic [LW-1:0] level_dn_s;
  logic [LW-1:0] duty_eff_s;

  assign step_tick_s = (step_cnt_r == STEP_LAST);
  assign target_s    = led_in ? FULL : ZERO;
  // Saturating neighbours: a reversal at an endpoint must not wrap.
  assign level_up_s  = (level_r == FULL) ? FULL : level_r + LW'(1);
  assign level_dn_s  = (level_r == ZERO) ? ZERO : level_r - LW'(1);

`ifdef LED_FADER_GAMMA_EN
  logic [2*PWM_BITS+1:0] level_sq_s;
  assign level_sq_s = {{LW{1'b0}}, level_r} * {{LW{1'b0}}, level_r};
  assign duty_eff_s = LW'(level_sq_s >> PWM_BITS);
`else
  assign duty_eff_s = level_r;
`endif

  // Step timer and fade state machine; a direction change never steps in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= OFF;
      level_r    <= ZERO;
      settled_r  <= 1'b1;
      step_cnt_r <= {SW{1'b0}};
    end else begin
      step_cnt_r <= step_tick_s ? {SW{1'b0}} : step_cnt_r + SW'(1);
      case (state_r)
        OFF: begin
          if (led_in) begin
            state_r   <= RISE;
            settled_r <= 1'b0;
          end
        end
        RISE: begin
          if (!led_in) begin
            state_r <= FALL;
          end else if (step_tick_s) begin
            level_r <= level_up_s;
            if (level_up_s == target_s) begin
              state_r   <= ON;
              settled_r <= 1'b1;
            end
          end
        end
        ON: begin
          if (!led_in) begin
            state_r   <= FALL;
            settled_r <= 1'b0;
          end
        end
        FALL: begin
          if (led_in) begin
            state_r <= RISE;
          end else if (step_tick_s) begin
            level_r <= level_dn_s;
            if (level_dn_s == target_s) begin
              state_r   <= OFF;
              settled_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r   <= OFF;
          level_r   <= ZERO;
          settled_r <= 1'b1;
        end
      endcase
    end
  end

  led_pwm #(
    .PWM_BITS (PWM_BITS)
  ) u_pwm (
    .clk     (clk),
    .rst_n   (rst_n),
    .duty    (duty_eff_s),
    .pwm_out (led_out)
  );

  assign level   = level_r;
  assign settled = settled_r;

endmodule
